// File: rtl/noc_pkg.sv
// Shared NoC definitions: output port codes and flit destination field layout.
package noc_pkg;

    typedef logic [2:0] port_code_t;

    localparam port_code_t PORT_N    = 3'b000;
    localparam port_code_t PORT_S    = 3'b001;
    localparam port_code_t PORT_W    = 3'b010;
    localparam port_code_t PORT_E    = 3'b011;
    localparam port_code_t PORT_L    = 3'b100;
    localparam port_code_t PORT_NONE = 3'b111;

    // Destination X occupies the top COORD_W bits; destination Y sits directly below it.
    function automatic int unsigned dest_x_lsb(int unsigned flit_w, int unsigned coord_w);
        return flit_w - coord_w;
    endfunction

    function automatic int unsigned dest_y_lsb(int unsigned flit_w, int unsigned coord_w);
        return flit_w - 2 * coord_w;
    endfunction

endpackage

// File: rtl/rr_xy_route_compute.sv
// Dimension-ordered XY routing: resolve X first, then Y, else deliver locally.
module rr_xy_route_compute
    import noc_pkg::*;
#(
    parameter int unsigned COORD_W = 2,
    parameter int unsigned MY_X    = 0,
    parameter int unsigned MY_Y    = 0
) (
    input  logic [COORD_W-1:0] dest_x,
    input  logic [COORD_W-1:0] dest_y,
    output port_code_t         port_code
);

    localparam logic [COORD_W-1:0] MyX = COORD_W'(MY_X);
    localparam logic [COORD_W-1:0] MyY = COORD_W'(MY_Y);

    always_comb begin
        port_code = PORT_L;
        if (dest_x > MyX) begin
            port_code = PORT_E;
        end else if (dest_x < MyX) begin
            port_code = PORT_W;
        end else if (dest_y > MyY) begin
            port_code = PORT_N;
        end else if (dest_y < MyY) begin
            port_code = PORT_S;
        end
    end

endmodule

// File: rtl/rr_input_buffer.sv
// Per-input-port flit FIFO with route precomputed at enqueue, grant-driven dequeue
// and one registered credit pulse per freed slot.
module rr_input_buffer
    import noc_pkg::*;
#(
    parameter int unsigned FLIT_W  = 32,
    parameter int unsigned COORD_W = 2,
    parameter int unsigned MY_X    = 0,
    parameter int unsigned MY_Y    = 0,
    parameter int unsigned DEPTH   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flit_valid_i,
    input  logic [FLIT_W-1:0] flit_i,
    input  logic              grant_n_i,
    input  logic              grant_s_i,
    input  logic              grant_w_i,
    input  logic              grant_e_i,
    input  logic              grant_l_i,
    output logic [2:0]        nexthop_addr_o,
    output logic [FLIT_W-1:0] flit_o,
    output logic              credit_o,
    output logic              overflow_o
);

    localparam int unsigned    PtrW      = $clog2(DEPTH);
    localparam int unsigned    XLsb      = dest_x_lsb(FLIT_W, COORD_W);
    localparam int unsigned    YLsb      = dest_y_lsb(FLIT_W, COORD_W);
    localparam logic [PtrW:0]  CountFull = (PtrW + 1)'(DEPTH);

    logic [FLIT_W-1:0] mem_flit [DEPTH];
    port_code_t        mem_code [DEPTH];

    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [PtrW:0]   count_q;
    logic            credit_q;
    logic            overflow_q;

    logic       empty;
    logic       full;
    logic       grant_sel;
    logic       deq;
    logic       enq;
    logic       wr_full;
    port_code_t head_code;
    port_code_t route_code;

    rr_xy_route_compute #(
        .COORD_W (COORD_W),
        .MY_X    (MY_X),
        .MY_Y    (MY_Y)
    ) u_route (
        .dest_x    (flit_i[XLsb +: COORD_W]),
        .dest_y    (flit_i[YLsb +: COORD_W]),
        .port_code (route_code)
    );

    assign empty     = (count_q == '0);
    assign full      = (count_q == CountFull);
    assign head_code = mem_code[rd_ptr_q];

    // Only the grant from the arbiter the head flit is routed to can pop it.
    always_comb begin
        grant_sel = 1'b0;
        case (head_code)
            PORT_N:  grant_sel = grant_n_i;
            PORT_S:  grant_sel = grant_s_i;
            PORT_W:  grant_sel = grant_w_i;
            PORT_E:  grant_sel = grant_e_i;
            PORT_L:  grant_sel = grant_l_i;
            default: grant_sel = 1'b0;
        endcase
    end

    assign deq     = grant_sel && !empty;
    // A dequeue in the same cycle frees a slot, so a write while full is still accepted.
    assign enq     = flit_valid_i && (!full || deq);
    assign wr_full = flit_valid_i && full && !deq;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            credit_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (enq) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (deq) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            case ({enq, deq})
                2'b10:   count_q <= count_q + (PtrW + 1)'(1);
                2'b01:   count_q <= count_q - (PtrW + 1)'(1);
                default: count_q <= count_q;
            endcase
            credit_q <= deq;
            if (wr_full) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            mem_flit[wr_ptr_q] <= flit_i;
            mem_code[wr_ptr_q] <= route_code;
        end
    end

    assign nexthop_addr_o = empty ? PORT_NONE : head_code;
    assign flit_o         = empty ? '0 : mem_flit[rd_ptr_q];
    assign credit_o       = credit_q;
    assign overflow_o     = overflow_q;

endmodule

// File: doc/rr_input_buffer.md
# rr_input_buffer

Per-input-port flit buffer of the NoC router, the upstream counterpart of each per-output round-robin arbiter processor. It stores incoming single-flit packets and precomputes each flit's XY next-hop port at enqueue. It presents the head flit's 3-bit next-hop address to the output arbiters, dequeues on grant, and returns one credit pulse upstream per freed slot. Those credit pulses are what the upstream router's arbiters consume as downstream credit.

## Interface
Parameters:
- FLIT_W, 32: flit width. Destination X in bits [FLIT_W-1 -: COORD_W], destination Y in the next COORD_W bits below.
- COORD_W, 2: coordinate field width.
- MY_X, 0: this router's X coordinate.
- MY_Y, 0: this router's Y coordinate.
- DEPTH, 4: FIFO entries. Must be a power of two, minimum 2.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- flit_valid_i  in  1  flit present on flit_i this cycle.
- flit_i  in  FLIT_W  incoming flit.
- grant_n_i, grant_s_i, grant_w_i, grant_e_i, grant_l_i  in  1 each  grant from the N/S/W/E/L output arbiter.
- nexthop_addr_o  out  3  head flit's output port code; PORT_NONE when empty.
- flit_o  out  FLIT_W  head flit; zero when empty.
- credit_o  out  1  one-cycle credit return to upstream.
- overflow_o  out  1  sticky error: write attempted while full.

## Operation
- Port codes: N=3'b000, S=3'b001, W=3'b010, E=3'b011, L=3'b100, NONE=3'b111.
- Route computation at enqueue:
  - dest_x>MY_X → E; dest_x<MY_X → W.
  - Otherwise dest_y>MY_Y → N; dest_y<MY_Y → S.
  - Otherwise L.
  - The 3-bit code is stored alongside the flit (entry width FLIT_W+3).
- Enqueue: flit_valid_i=1 and not full → write at wr_ptr; wr_ptr and count increment.
- Full write: flit_valid_i=1 while full and no dequeue → flit dropped, overflow_o set and held until reset.
- Dequeue condition: the grant matching the head's stored code is 1 and the FIFO is not empty.
- Non-matching grants, grants while empty, and multiple grants in one cycle: at most one dequeue, and only via the matching grant. Other grants are ignored.
- Simultaneous enqueue and dequeue: both happen and count is unchanged. When full this is accepted with no overflow.
- Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits, range 0..DEPTH.
- credit_o is a registered copy of the dequeue event.
- Upstream starts with DEPTH credits after reset.

## Timing
- Reset values: count=0, pointers=0, nexthop_addr_o=3'b111, flit_o=0, credit_o=0, overflow_o=0. FIFO contents are don't-care.
- No bypass. A flit written at edge t into an empty FIFO appears on nexthop_addr_o and flit_o after edge t, i.e. it is visible in cycle t+1.
- nexthop_addr_o and flit_o are driven combinationally from the head entry's registers, with no logic depth beyond the read mux.
- Dequeue occurs at the edge where the matching grant is sampled high. The next entry, or NONE, is visible the following cycle.
- credit_o rises the cycle after the dequeue edge and lasts exactly one cycle per dequeue. Back-to-back dequeues give back-to-back credit pulses.
- Reset asserted mid-operation: all stored flits are discarded and no credit pulses are issued for them. The upstream credit counter is reset by the same reset.

## Structure
- Package noc_pkg holds:
  - port code localparams PORT_N, PORT_S, PORT_W, PORT_E, PORT_L, PORT_NONE;
  - the flit destination field offset functions;
  - the typedef port_code_t (logic [2:0]).
- Sub-module rr_xy_route_compute: combinational; inputs dest_x, dest_y, MY_X/MY_Y parameters; output port_code_t. It is shared later by the local injection port.
- The FIFO storage, pointers, count, credit register and overflow flag stay in rr_input_buffer.

## Test plan
- Route decode (MY_X=1, MY_Y=1): inject dest (2,1), (0,1), (1,2), (1,0), (1,1) with a matching grant one cycle after each → nexthop_addr_o sequence 011, 010, 000, 001, 100. Five credit_o pulses, each one cycle after its grant.
- Fill and overflow (DEPTH=4): write 5 flits with no grants → count=4, fifth flit dropped, overflow_o=1 from the cycle after the fifth write until reset, no credit_o.
- Full with simultaneous enqueue and dequeue: FIFO full, valid write plus matching grant in the same cycle → count stays 4, overflow_o=0, one credit_o pulse, new flit at the tail.
- Wrong grant: head code E, assert grant_w_i only → no dequeue, no credit. Then grant_e_i → dequeue, credit_o high next cycle.
- Pointer wrap: stream 10 flits through with grants every cycle → FIFO order preserved across the wrap, 10 credit pulses, empty reads 3'b111 and zero flit.
- Reset mid-stream: 3 flits stored, assert reset for 1 cycle → nexthop_addr_o=3'b111, credit_o=0, overflow_o=0, and the next write is visible one cycle later.
